// File: rtl/stall_mem_pkg.sv
// stall_mem_pkg: shared FSM state type and size constants for the stalling memory responder.
package stall_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int LATENCY_DEF = 4;
  localparam int DW = 16;
endpackage

// File: rtl/stall_mem_resp_if.sv
// stall_mem_resp_if: request/response bus between a requester (master) and the memory (slave).
interface stall_mem_resp_if;
  import stall_mem_pkg::*;
  logic [15:0] Addr;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic Rd, Wr, createdump, Done, Stall, CacheHit, err;
  modport master (output Addr, DataIn, Rd, Wr, createdump, input DataOut, Done, Stall, CacheHit, err);
  modport slave (input Addr, DataIn, Rd, Wr, createdump, output DataOut, Done, Stall, CacheHit, err);
endinterface

// File: rtl/stall_mem_array.sv
// stall_mem_array: 2**AW x 16-bit word store, synchronous write, asynchronous read.
module stall_mem_array
  import stall_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  input  logic          i_dump
);
  logic [DW-1:0] r_mem [2**AW];
  logic w_unused_dump;
  // dump is a simulation-side hook; it has no hardware behaviour
  assign w_unused_dump = i_dump;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/stall_mem_resp.sv
// stall_mem_resp: fixed-latency stalling memory responder with error pulses.
// Define STALL_MEM_RESP_HITBUF_EN to add a one-entry hit buffer that completes matching reads in one cycle.
module stall_mem_resp
  import stall_mem_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int AW = 8
) (
  input logic clk,
  input logic rst,
  stall_mem_resp_if.slave bus
);
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data, w_rdata, w_hd, w_dout;
  logic r_wr, r_err, r_hit;
  logic w_bad, w_acc, w_hit, w_live, w_ok, w_unused;
  assign w_bad = (bus.Rd & bus.Wr) | ((bus.Rd | bus.Wr) & bus.Addr[0]);
  assign w_acc = (r_state == IDLE) & (bus.Rd | bus.Wr);
`ifdef STALL_MEM_RESP_HITBUF_EN
  logic r_hv;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_hd;
  assign w_hit = r_hv & bus.Rd & ~bus.Wr & ~bus.Addr[0] & (bus.Addr[AW:1] == r_tag);
  assign w_hd = r_hd;
  always_ff @(posedge clk)
    if (rst) r_hv <= 1'b0;
    else if (w_ok) begin
      r_hv <= 1'b1;
      r_tag <= r_addr;
      r_hd <= r_wr ? r_data : w_dout;
    end
  assign bus.CacheHit = w_ok & r_hit;
`else
  assign w_hit = 1'b0;
  assign w_hd = '0;
  assign bus.CacheHit = 1'b0;
`endif
  // errors and buffer hits skip BUSY and complete in the following cycle
  always_comb
    w_next = r_state == IDLE ? (w_acc ? ((w_bad | w_hit) ? DONE : BUSY) : IDLE) :
             r_state == BUSY ? (r_cnt <= 4'd1 ? DONE : BUSY) : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_hit <= 1'b0;
      r_wr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_addr <= bus.Addr[AW:1];
        r_data <= bus.DataIn;
        r_wr <= bus.Wr;
        r_err <= w_bad;
        r_hit <= w_hit;
        r_cnt <= (w_bad | w_hit) ? '0 : 4'(LATENCY - 1);
      end else if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
    end
  assign w_live = (r_state == DONE) & ~rst;
  assign w_ok = w_live & ~r_err;
  assign w_dout = (w_ok & ~r_wr) ? (r_hit ? w_hd : w_rdata) : '0;
  assign bus.DataOut = w_dout;
  assign bus.Done = w_live;
  assign bus.err = w_live & r_err;
  assign bus.Stall = (r_state == BUSY) & ~rst;
  assign w_unused = ^bus.Addr[15:AW+1];
  stall_mem_array #(.AW(AW)) u_array (
    .clk(clk),
    .i_we(w_ok & r_wr),
    .i_addr(r_addr),
    .i_wdata(r_data),
    .o_rdata(w_rdata),
    .i_dump(bus.createdump)
  );
endmodule

// File: tb/tb_stall_mem_resp.sv
// tb_stall_mem_resp: randomized self-checking bench against a transaction-level memory model.
module tb_stall_mem_resp;
  localparam int L = 4;
`ifdef STALL_MEM_RESP_HITBUF_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  stall_mem_resp_if bus();
  stall_mem_resp #(.LATENCY(L), .AW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [15:0] m_mem [256];
  bit hb_v = 1'b0;
  logic [7:0] hb_tag;
  logic [15:0] hb_d;

  // Expected completion cycle (-1 = none), stall count, data, err and hit for one request.
  task automatic model(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       output int dc, output int st, output logic [15:0] q, output bit e, output bit h);
    logic [7:0] w;
    w = a[8:1];
    dc = -1; st = 0; q = 16'h0; e = 1'b0; h = 1'b0;
    if (rd || wr) begin
      e = (rd && wr) || a[0];
      if (e) dc = 1;
      else begin
        h = HB && rd && hb_v && hb_tag == w;
        dc = h ? 1 : L;
        st = h ? 0 : L - 1;
        if (rd) q = h ? hb_d : m_mem[w];
        else m_mem[w] = d;
        if (HB) begin
          hb_v = 1'b1;
          hb_tag = w;
          hb_d = rd ? q : d;
        end
      end
    end
  endtask

  task automatic drive_idle();
    bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = 16'h0; bus.DataIn = 16'h0; bus.createdump = 1'b0;
  endtask

  // Presents one request and watches outputs each cycle; returns at the Done cycle or after the bound.
  task automatic run_op(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d, input bit noise,
                        output int dc, output int st, output logic [15:0] q, output bit e, output bit h);
    dc = -1; st = 0; q = 16'h0; e = 1'b0; h = 1'b0;
    @(negedge clk);
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      if (bus.Stall === 1'b1) st++;
      if (bus.Done === 1'b1) begin
        dc = k; q = bus.DataOut; e = bus.err; h = bus.CacheHit;
      end
      if (noise && bus.Stall === 1'b1) begin
        bus.Rd = 1'($urandom); bus.Wr = 1'($urandom);
        bus.Addr = 16'($urandom); bus.DataIn = 16'($urandom); bus.createdump = 1'($urandom);
      end else drive_idle();
      if (dc > 0) break;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    hb_v = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    total++; if (bus.Stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.Stall); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    total++; if (bus.CacheHit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", bus.CacheHit); end
    total++; if (bus.DataOut !== 16'h0) begin bad++; $display("FAIL reset_dout: got %h want 0000", bus.DataOut); end
    rst = 1'b0;
  endtask

  task automatic test_prefill();
    int dc, st, edc, est; logic [15:0] q, eq, v; bit e, h, ee, eh;
    for (int w = 0; w < 40; w++) begin
      v = 16'($urandom);
      if (v == 16'h1234) v = 16'h4321;
      model(1'b0, 1'b1, 16'(w * 2), v, edc, est, eq, ee, eh);
      run_op(1'b0, 1'b1, 16'(w * 2), v, 1'b0, dc, st, q, e, h);
      total++; if (dc !== edc) begin bad++; $display("FAIL prefill_done_cycle w%0d: got %0d want %0d", w, dc, edc); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL prefill_err w%0d: got %b want 0", w, e); end
    end
  endtask

  task automatic test_write_read();
    int dc, st, edc, est; logic [15:0] q, eq; bit e, h, ee, eh;
    model(1'b0, 1'b1, 16'h0010, 16'hBEEF, edc, est, eq, ee, eh);
    run_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, dc, st, q, e, h);
    total++; if (dc !== L) begin bad++; $display("FAIL wr_done_cycle: got %0d want %0d", dc, L); end
    total++; if (st !== L - 1) begin bad++; $display("FAIL wr_stall_cycles: got %0d want %0d", st, L - 1); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
    total++; if (q !== 16'h0) begin bad++; $display("FAIL wr_dout: got %h want 0000", q); end
    model(1'b1, 1'b0, 16'h0010, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (q !== 16'hBEEF) begin bad++; $display("FAIL rd_beef: got %h want beef", q); end
    total++; if (dc !== edc) begin bad++; $display("FAIL rd_done_cycle: got %0d want %0d", dc, edc); end
  endtask

  task automatic test_misaligned();
    int dc, st, edc, est; logic [15:0] q, eq; bit e, h, ee, eh;
    model(1'b1, 1'b0, 16'h0011, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0011, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (dc !== 1) begin bad++; $display("FAIL mis_done_cycle: got %0d want 1", dc); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", e); end
    total++; if (st !== 0) begin bad++; $display("FAIL mis_stall: got %0d want 0", st); end
    total++; if (q !== 16'h0) begin bad++; $display("FAIL mis_dout: got %h want 0000", q); end
    model(1'b1, 1'b0, 16'h0010, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (q !== 16'hBEEF) begin bad++; $display("FAIL mis_unchanged: got %h want beef", q); end
  endtask

  task automatic test_both();
    int dc, st, edc, est; logic [15:0] q, eq, prev; bit e, h, ee, eh;
    prev = m_mem[8'h10];
    model(1'b1, 1'b1, 16'h0020, ~prev, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b1, 16'h0020, ~prev, 1'b0, dc, st, q, e, h);
    total++; if (dc !== 1) begin bad++; $display("FAIL both_done_cycle: got %0d want 1", dc); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL both_err: got %b want 1", e); end
    model(1'b1, 1'b0, 16'h0020, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (q !== prev) begin bad++; $display("FAIL both_unchanged: got %h want %h", q, prev); end
  endtask

  task automatic test_reset_abort();
    int dc, st, edc, est; logic [15:0] q, eq, prev; bit e, h, ee, eh;
    prev = m_mem[8'h18];
    @(negedge clk);
    bus.Wr = 1'b1; bus.Addr = 16'h0030; bus.DataIn = 16'h1234;
    @(negedge clk);
    drive_idle();
    total++; if (bus.Stall !== 1'b1) begin bad++; $display("FAIL abort_stall: got %b want 1", bus.Stall); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.Stall !== 1'b0) begin bad++; $display("FAIL abort_stall_in_rst: got %b want 0", bus.Stall); end
    @(negedge clk);
    total++; if ({bus.Done, bus.Stall, bus.err, bus.CacheHit} !== 4'b0) begin bad++; $display("FAIL abort_flags: got %b want 0000", {bus.Done, bus.Stall, bus.err, bus.CacheHit}); end
    total++; if (bus.DataOut !== 16'h0) begin bad++; $display("FAIL abort_dout: got %h want 0000", bus.DataOut); end
    rst = 1'b0;
    hb_v = 1'b0;
    repeat (L + 2) begin
      @(negedge clk);
      total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", bus.Done); end
    end
    model(1'b1, 1'b0, 16'h0030, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (q === 16'h1234) begin bad++; $display("FAIL abort_committed: got %h want not 1234", q); end
    total++; if (q !== prev) begin bad++; $display("FAIL abort_readback: got %h want %h", q, prev); end
    total++; if (dc !== L) begin bad++; $display("FAIL abort_buffer_cleared: got %0d want %0d", dc, L); end
  endtask

  task automatic test_hitbuf();
    int dc, st, edc, est; logic [15:0] q, eq; bit e, h, ee, eh;
    model(1'b0, 1'b1, 16'h0040, 16'h5A5A, edc, est, eq, ee, eh);
    run_op(1'b0, 1'b1, 16'h0040, 16'h5A5A, 1'b0, dc, st, q, e, h);
    total++; if (dc !== L) begin bad++; $display("FAIL hb_wr_done_cycle: got %0d want %0d", dc, L); end
    model(1'b1, 1'b0, 16'h0040, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (q !== 16'h5A5A) begin bad++; $display("FAIL hb_rd_data: got %h want 5a5a", q); end
    total++; if (dc !== (HB ? 1 : L)) begin bad++; $display("FAIL hb_rd_done_cycle: got %0d want %0d", dc, HB ? 1 : L); end
    total++; if (h !== HB) begin bad++; $display("FAIL hb_rd_hit: got %b want %b", h, HB); end
    total++; if (st !== (HB ? 0 : L - 1)) begin bad++; $display("FAIL hb_rd_stall: got %0d want %0d", st, HB ? 0 : L - 1); end
    model(1'b1, 1'b0, 16'h0042, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0042, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (dc !== L) begin bad++; $display("FAIL hb_miss_done_cycle: got %0d want %0d", dc, L); end
    total++; if (h !== 1'b0) begin bad++; $display("FAIL hb_miss_hit: got %b want 0", h); end
    total++; if (q !== eq) begin bad++; $display("FAIL hb_miss_data: got %h want %h", q, eq); end
  endtask

  task automatic test_noise();
    int dc, st, edc, est; logic [15:0] q, eq, a, d; bit e, h, ee, eh;
    a = 16'($urandom_range(0, 39) * 2);
    d = 16'($urandom);
    model(1'b0, 1'b1, a, d, edc, est, eq, ee, eh);
    run_op(1'b0, 1'b1, a, d, 1'b1, dc, st, q, e, h);
    total++; if (dc !== L) begin bad++; $display("FAIL noise_done_cycle: got %0d want %0d", dc, L); end
    total++; if (st !== L - 1) begin bad++; $display("FAIL noise_stall: got %0d want %0d", st, L - 1); end
    repeat (3) begin
      @(negedge clk);
      total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL noise_extra_done: got %b want 0", bus.Done); end
    end
    model(1'b1, 1'b0, a, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, a, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (q !== d) begin bad++; $display("FAIL noise_readback: got %h want %h", q, d); end
  endtask

  task automatic test_back_to_back();
    int dc, st, edc, est; logic [15:0] q, eq, d1, d2; bit e, h, ee, eh;
    d1 = 16'($urandom); d2 = ~d1;
    model(1'b0, 1'b1, 16'h0002, d1, edc, est, eq, ee, eh);
    run_op(1'b0, 1'b1, 16'h0002, d1, 1'b0, dc, st, q, e, h);
    total++; if (dc !== edc) begin bad++; $display("FAIL b2b_first: got %0d want %0d", dc, edc); end
    model(1'b0, 1'b1, 16'h0004, d2, edc, est, eq, ee, eh);
    run_op(1'b0, 1'b1, 16'h0004, d2, 1'b0, dc, st, q, e, h);
    total++; if (dc !== edc) begin bad++; $display("FAIL b2b_second: got %0d want %0d", dc, edc); end
    model(1'b1, 1'b0, 16'h0002, 16'h0, edc, est, eq, ee, eh);
    run_op(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, dc, st, q, e, h);
    total++; if (dc !== L) begin bad++; $display("FAIL b2b_read_cycle: got %0d want %0d", dc, L); end
    total++; if (q !== d1) begin bad++; $display("FAIL b2b_read_data: got %h want %h", q, d1); end
  endtask

  task automatic test_random();
    int dc, st, edc, est, kind; logic [15:0] q, eq, a, d; bit e, h, ee, eh, rd, wr;
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind <= 5);
      wr = (kind == 1) || (kind >= 6);
      a = 16'($urandom_range(0, 39) * 2) | 16'($urandom_range(0, 3) == 0);
      d = 16'($urandom);
      model(rd, wr, a, d, edc, est, eq, ee, eh);
      run_op(rd, wr, a, d, 1'($urandom), dc, st, q, e, h);
      total++; if (dc !== edc) begin bad++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", i, dc, edc); end
      total++; if (st !== est) begin bad++; $display("FAIL rnd%0d_stall: got %0d want %0d", i, st, est); end
      total++; if (q !== eq) begin bad++; $display("FAIL rnd%0d_dout: got %h want %h", i, q, eq); end
      total++; if (e !== ee) begin bad++; $display("FAIL rnd%0d_err: got %b want %b", i, e, ee); end
      total++; if (h !== eh) begin bad++; $display("FAIL rnd%0d_hit: got %b want %b", i, h, eh); end
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_write_read();
    test_misaligned();
    test_both();
    test_reset_abort();
    test_hitbuf();
    test_noise();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
